// File: rtl/e_md_req.sv
// rtl/e_md_req.sv - E-stage request sequencer toward the HI/LO multiply/divide unit
module e_md_req #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [3:0]  in_op,
   input  logic [31:0] in_rs,
   input  logic [31:0] in_rt,
   output logic        md_req,
   output logic [3:0]  md_op,
   output logic [31:0] md_a,
   output logic [31:0] md_b,
   input  logic        md_ack,
   input  logic        md_busy,
   input  logic [31:0] md_rdata,
   output logic        stall,
   output logic        rd_valid,
   output logic [31:0] rd_data
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CNT_W   = ($clog2(MAX_LAT + 1) < 5) ? 5 : $clog2(MAX_LAT + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              md_req_q, md_req_d;
   logic [3:0]        md_op_q, md_op_d;
   logic [31:0]       md_a_q, md_a_d;
   logic [31:0]       md_b_q, md_b_d;
   logic              rd_valid_q, rd_valid_d;
   logic [31:0]       rd_data_q, rd_data_d;

   logic              op_valid;
   logic              accept;
   logic [CNT_W-1:0]  cnt_dec;

   // Next-state, command latch, latency countdown and stall generation
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      md_req_d   = md_req_q;
      md_op_d    = md_op_q;
      md_a_d     = md_a_q;
      md_b_d     = md_b_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;

      op_valid = (in_op >= OP_MULT) && (in_op <= OP_MTLO);
      accept   = (state_q == S_IDLE) && in_valid && op_valid;
      // Saturating decrement: the counter parks at zero while the unit is still busy
      cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               md_op_d  = in_op;
               md_a_d   = in_rs;
               md_b_d   = in_rt;
               md_req_d = 1'b1;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (md_ack) begin
               md_req_d = 1'b0;
               case (md_op_q)
                  OP_MULT, OP_MULTU: begin
                     cnt_d   = CNT_W'(MULT_LAT);
                     state_d = S_WAIT;
                  end
                  OP_DIV, OP_DIVU: begin
                     cnt_d   = CNT_W'(DIV_LAT);
                     state_d = S_WAIT;
                  end
                  OP_MFHI, OP_MFLO: begin
                     rd_data_d  = md_rdata;
                     rd_valid_d = 1'b1;
                     state_d    = S_IDLE;
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end
         S_WAIT: begin
            // Leave on the cycle the count runs out, so WAIT lasts exactly LAT cycles
            cnt_d = cnt_dec;
            if ((cnt_dec == '0) && !md_busy) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      stall = (state_q != S_IDLE) || accept;
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         md_req_q   <= 1'b0;
         md_op_q    <= 4'd0;
         md_a_q     <= 32'd0;
         md_b_q     <= 32'd0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         md_req_q   <= md_req_d;
         md_op_q    <= md_op_d;
         md_a_q     <= md_a_d;
         md_b_q     <= md_b_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign md_req   = md_req_q;
   assign md_op    = md_op_q;
   assign md_a     = md_a_q;
   assign md_b     = md_b_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_e_md_req.sv
// tb/tb_e_md_req.sv - directed scoreboard bench for e_md_req
module tb_e_md_req;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [3:0]  in_op;
   logic [31:0] in_rs;
   logic [31:0] in_rt;
   logic        md_req;
   logic [3:0]  md_op;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic        md_ack;
   logic        md_busy;
   logic [31:0] md_rdata;
   logic        stall;
   logic        rd_valid;
   logic [31:0] rd_data;

   e_md_req #(.MULT_LAT(5), .DIV_LAT(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_op    (in_op),
      .in_rs    (in_rs),
      .in_rt    (in_rt),
      .md_req   (md_req),
      .md_op    (md_op),
      .md_a     (md_a),
      .md_b     (md_b),
      .md_ack   (md_ack),
      .md_busy  (md_busy),
      .md_rdata (md_rdata),
      .stall    (stall),
      .rd_valid (rd_valid),
      .rd_data  (rd_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } cmd_t;

   cmd_t        cmd_q[$];
   logic [31:0] data_q[$];

   int passed = 0;
   int total  = 0;
   int stall_cnt = 0;
   int req_cnt   = 0;
   int rdv_cnt   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      cmd_t c;
      c.op = op;
      c.a  = a;
      c.b  = b;
      cmd_q.push_back(c);
   endtask

   // Mid-cycle monitor: activity counters plus scoreboard pops on handshakes
   always @(negedge clk) begin
      if (!reset) begin
         if (stall)    stall_cnt++;
         if (md_req)   req_cnt++;
         if (rd_valid) rdv_cnt++;
         if (md_req && md_ack) begin
            if (cmd_q.size() == 0) begin
               check("unexpected_cmd", 32'd1, 32'd0);
            end else begin
               cmd_t c;
               c = cmd_q.pop_front();
               check("cmd_op", 32'(md_op), 32'(c.op));
               check("cmd_a", md_a, c.a);
               check("cmd_b", md_b, c.b);
            end
         end
         if (rd_valid) begin
            if (data_q.size() == 0) begin
               check("unexpected_rd", 32'd1, 32'd0);
            end else begin
               check("rd_data", rd_data, data_q.pop_front());
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s_stall, s_req, s_rdv, n;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_op    = 4'd0;
      in_rs    = 32'd0;
      in_rt    = 32'd0;
      md_ack   = 1'b1;
      md_busy  = 1'b0;
      md_rdata = 32'd14;
      #1;
      check("rst_md_req", 32'(md_req), 32'd0);
      check("rst_md_op", 32'(md_op), 32'd0);
      check("rst_md_a", md_a, 32'd0);
      check("rst_md_b", md_b, 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      tick();
      tick();
      reset = 1'b0;

      // mult 3 * -2 with ack tied high
      s_stall = stall_cnt; s_req = req_cnt;
      in_valid = 1'b1; in_op = 4'd1; in_rs = 32'd3; in_rt = 32'hFFFF_FFFE;
      push_cmd(4'd1, 32'd3, 32'hFFFF_FFFE);
      tick();
      in_valid = 1'b0;
      check("mult_issue_req", 32'(md_req), 32'd1);
      check("mult_issue_a", md_a, 32'd3);
      check("mult_issue_b", md_b, 32'hFFFF_FFFE);
      repeat (10) tick();
      check("mult_stall_cycles", 32'(stall_cnt - s_stall), 32'd7);
      check("mult_req_cycles", 32'(req_cnt - s_req), 32'd1);
      check("mult_idle_stall", 32'(stall), 32'd0);

      // divu 100/7 followed by a held mflo
      s_stall = stall_cnt;
      in_valid = 1'b1; in_op = 4'd4; in_rs = 32'd100; in_rt = 32'd7;
      push_cmd(4'd4, 32'd100, 32'd7);
      tick();
      in_op = 4'd6; in_rs = 32'd0; in_rt = 32'd0;
      push_cmd(4'd6, 32'd0, 32'd0);
      data_q.push_back(32'd14);
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (md_req && md_op == 4'd6) begin
            n = i;
            break;
         end
      end
      in_valid = 1'b0;
      check("mflo_issue_delay", 32'(n), 32'd12);
      tick();
      check("mflo_rd_valid", 32'(rd_valid), 32'd1);
      check("mflo_rd_data", rd_data, 32'd14);
      tick();
      check("mflo_rd_valid_pulse", 32'(rd_valid), 32'd0);
      check("divu_mflo_stall_cycles", 32'(stall_cnt - s_stall), 32'd14);

      // mthi with the ack held off for three cycles
      s_stall = stall_cnt; s_req = req_cnt; s_rdv = rdv_cnt;
      md_ack = 1'b0; md_rdata = 32'h5555_AAAA;
      in_valid = 1'b1; in_op = 4'd7; in_rs = 32'hDEAD_BEEF; in_rt = 32'd1;
      push_cmd(4'd7, 32'hDEAD_BEEF, 32'd1);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("mthi_wait_req", 32'(md_req), 32'd1);
         check("mthi_wait_a", md_a, 32'hDEAD_BEEF);
         check("mthi_wait_stall", 32'(stall), 32'd1);
         tick();
      end
      md_ack = 1'b1;
      check("mthi_ack_a", md_a, 32'hDEAD_BEEF);
      tick();
      tick();
      check("mthi_req_cycles", 32'(req_cnt - s_req), 32'd4);
      check("mthi_stall_cycles", 32'(stall_cnt - s_stall), 32'd5);
      check("mthi_no_rd_valid", 32'(rdv_cnt - s_rdv), 32'd0);
      check("mthi_rd_data_kept", rd_data, 32'd14);

      // multu with md_busy held past the latency count
      s_stall = stall_cnt;
      in_valid = 1'b1; in_op = 4'd2; in_rs = 32'd7; in_rt = 32'd9;
      push_cmd(4'd2, 32'd7, 32'd9);
      tick();
      in_valid = 1'b0;
      md_busy = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (k == 6) check("busy_wait_stall_at_zero", 32'(stall), 32'd1);
      end
      md_busy = 1'b0;
      check("busy_still_stalled", 32'(stall), 32'd1);
      tick();
      check("busy_released_stall", 32'(stall), 32'd0);
      check("busy_stall_cycles", 32'(stall_cnt - s_stall), 32'd11);

      // reset asserted in the middle of a div WAIT
      in_valid = 1'b1; in_op = 4'd3; in_rs = 32'd50; in_rt = 32'd5;
      push_cmd(4'd3, 32'd50, 32'd5);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      check("div_in_wait_stall", 32'(stall), 32'd1);
      s_rdv = rdv_cnt;
      reset = 1'b1;
      #1;
      check("abort_md_req", 32'(md_req), 32'd0);
      check("abort_stall", 32'(stall), 32'd0);
      check("abort_rd_valid", 32'(rd_valid), 32'd0);
      check("abort_counter", 32'(dut.cnt_q), 32'd0);
      check("abort_md_op", 32'(md_op), 32'd0);
      check("abort_md_a", md_a, 32'd0);
      check("abort_rd_data", rd_data, 32'd0);
      tick();
      reset = 1'b0;
      md_rdata = 32'h1234_ABCD;
      in_valid = 1'b1; in_op = 4'd5; in_rs = 32'd0; in_rt = 32'd0;
      push_cmd(4'd5, 32'd0, 32'd0);
      data_q.push_back(32'h1234_ABCD);
      tick();
      in_valid = 1'b0;
      check("mfhi_first_edge_req", 32'(md_req), 32'd1);
      check("mfhi_first_edge_op", 32'(md_op), 32'd5);
      tick();
      check("mfhi_rd_valid", 32'(rd_valid), 32'd1);
      check("mfhi_rd_data", rd_data, 32'h1234_ABCD);
      tick();
      check("abort_no_extra_rd", 32'(rdv_cnt - s_rdv), 32'd1);

      // undefined and none opcodes never start a transaction
      s_req = req_cnt;
      in_valid = 1'b1; in_op = 4'd12; in_rs = 32'd1; in_rt = 32'd2;
      #1;
      check("op12_stall", 32'(stall), 32'd0);
      tick();
      tick();
      check("op12_md_req", 32'(md_req), 32'd0);
      check("op12_stall_later", 32'(stall), 32'd0);
      in_op = 4'd0;
      #1;
      check("op0_stall", 32'(stall), 32'd0);
      tick();
      in_valid = 1'b0;
      tick();
      check("ignored_ops_req_cycles", 32'(req_cnt - s_req), 32'd0);

      check("cmd_queue_drained", 32'(cmd_q.size()), 32'd0);
      check("data_queue_drained", 32'(data_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
